vram_arbiter: RTL and testbench

- Shares the single-port VGA frame RAM (16-bit words, 14-bit word address, 1-cycle registered read) between two requesters.
- Requester 1: the VGA controller, which reads 8-bit pixels by byte address.
- Requester 2: the CPU, which reads and writes 16-bit words with a req/ack handshake.
- VGA has fixed priority; a starvation counter guarantees CPU progress.
- Sits between the VGA controller, the CPU memory stage and the VGARAM instance.

---
 rtl/vram_pkg.sv | 12 +
 rtl/vram_tag_pipe.sv | 22 ++
 rtl/vram_arbiter.sv | 77 +++++++
 tb/tb_vram_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and grant/tag types for the VGA frame RAM arbiter
package vram_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 16;
  localparam int PIX_W = 8;
  localparam int VRAM_RD_LAT = 2;
  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU_RD, GNT_CPU_WR} gnt_t;
  typedef struct packed {
    gnt_t gnt;
    logic sel;
  } tag_t;
endpackage

// File: rtl/vram_tag_pipe.sv
// vram_tag_pipe: delays the grant tag and byte select to line up with RAM read data
//   clk, rst_n : clock, async active-low reset (flushes to GNT_NONE)
//   din        : tag issued alongside the RAM address
//   dout       : tag aligned with ram_dout, VRAM_RD_LAT edges later
module vram_tag_pipe
  import vram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  tag_t din,
  output tag_t dout
);
  tag_t q [VRAM_RD_LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < VRAM_RD_LAT; i++) q[i] <= '{gnt: GNT_NONE, sel: 1'b0};
    end else begin
      q[0] <= din;
      for (int i = 1; i < VRAM_RD_LAT; i++) q[i] <= q[i-1];
    end
  assign dout = q[VRAM_RD_LAT-1];
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VGA frame RAM between VGA pixel reads and CPU word accesses
//   vga_req/vga_addr -> vga_data/vga_valid/vga_miss : byte reads, fixed priority
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack : word access, req/ack
//   ram_addr/ram_we/ram_din <- ram_dout : RAM port with 1-cycle registered read
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int STARVE_LIMIT = 15,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vga_req,
  input  logic [ADDR_W:0]        vga_addr,
  output logic [PIX_W-1:0]       vga_data,
  output logic                   vga_valid,
  output logic                   vga_miss,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [VRAM_DATA_W-1:0] cpu_wdata,
  output logic [VRAM_DATA_W-1:0] cpu_rdata,
  output logic                   cpu_ack,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [VRAM_DATA_W-1:0] ram_din,
  input  logic [VRAM_DATA_W-1:0] ram_dout
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic cpu_busy, cpu_elig, force_cpu, gnt_cpu, gnt_vga, cpu_done;
  tag_t tag_in, tag_out;
  // cpu_ack still high counts as in flight so a held req is not re-granted
  always_comb begin
    cpu_elig = cpu_req & ~cpu_busy & ~cpu_ack;
    force_cpu = vga_req & cpu_elig & (wait_cnt == LIM);
    gnt_cpu = force_cpu | (~vga_req & cpu_elig);
    gnt_vga = vga_req & ~force_cpu;
    wait_nxt = (cpu_elig & gnt_vga) ? ((wait_cnt == LIM) ? wait_cnt : wait_cnt + 1'b1) : '0;
    tag_in.gnt = gnt_vga ? GNT_VGA : gnt_cpu ? (cpu_we ? GNT_CPU_WR : GNT_CPU_RD) : GNT_NONE;
    tag_in.sel = gnt_vga & vga_addr[0];
    cpu_done = (tag_out.gnt == GNT_CPU_RD) | (tag_out.gnt == GNT_CPU_WR);
  end
  vram_tag_pipe u_tag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (tag_in),
    .dout (tag_out)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wait_cnt <= '0;
      cpu_busy <= 1'b0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_din <= '0;
      vga_miss <= 1'b0;
      vga_valid <= 1'b0;
      vga_data <= '0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      vga_miss <= force_cpu;
      ram_we <= gnt_cpu & cpu_we;
      if (gnt_vga) ram_addr <= vga_addr[ADDR_W:1];
      else if (gnt_cpu) ram_addr <= cpu_addr;
      if (gnt_cpu) ram_din <= cpu_wdata;
      if (gnt_cpu) cpu_busy <= 1'b1;
      else if (cpu_done) cpu_busy <= 1'b0;
      vga_valid <= tag_out.gnt == GNT_VGA;
      if (tag_out.gnt == GNT_VGA) vga_data <= tag_out.sel ? ram_dout[15:8] : ram_dout[7:0];
      cpu_ack <= cpu_done;
      if (tag_out.gnt == GNT_CPU_RD) cpu_rdata <= ram_dout;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a behavioural RAM
module tb_vram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vga_req = 1'b0, vga_valid, vga_miss;
  logic [14:0] vga_addr = '0;
  logic [7:0] vga_data;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
  logic [13:0] cpu_addr = '0, ram_addr;
  logic [15:0] cpu_wdata = '0, cpu_rdata, ram_din, ram_dout;
  logic ram_we;
  logic [15:0] mem [0:16383];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end
  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
    .vga_valid(vga_valid), .vga_miss(vga_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic outs_zero(input string tag);
    check({tag, "_outs"}, {vga_data, vga_valid, vga_miss, cpu_ack, ram_we}, '0);
    check({tag, "_ram"}, {ram_addr, ram_din}, '0);
    check({tag, "_rdata"}, cpu_rdata, '0);
  endtask
  // one isolated CPU access: grant at the first edge, ack two edges later
  task automatic cpu_op(input string tag, input logic we, input logic [13:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    tick;
    check({tag, "_addr"}, ram_addr, a);
    check({tag, "_we"}, ram_we, we);
    check({tag, "_ack0"}, cpu_ack, 1'b0);
    tick;
    check({tag, "_we1"}, ram_we, 1'b0);
    check({tag, "_ack1"}, cpu_ack, 1'b0);
    tick;
    check({tag, "_ack2"}, cpu_ack, 1'b1);
    check({tag, "_rdata"}, cpu_rdata, exp_rd);
    cpu_req = 1'b0;
    tick;
    check({tag, "_ack3"}, cpu_ack, 1'b0);
  endtask
  initial begin
    int grant_edge, miss_cnt, ack_edge, valid_cnt, we_cnt, ack_cnt, we2_edge;
    repeat (2) tick;
    outs_zero("reset");
    rst_n = 1'b1;
    cpu_op("wr_beef", 1'b1, 14'h0123, 16'hBEEF, 16'h0000);
    check("mem_beef", mem[14'h0123], 16'hBEEF);
    cpu_op("rd_beef", 1'b0, 14'h0123, 16'h0000, 16'hBEEF);
    check("rdata_hold", cpu_rdata, 16'hBEEF);
    cpu_op("wr_a55a", 1'b1, 14'h0040, 16'hA55A, 16'hBEEF);
    // back-to-back pixel reads of both bytes of word 0x0040
    vga_req = 1'b1; vga_addr = 15'h0080;
    tick;
    check("vga_addr", ram_addr, 14'h0040);
    vga_addr = 15'h0081;
    tick;
    vga_req = 1'b0;
    check("vga_valid_early", vga_valid, 1'b0);
    tick;
    check("vga_lo", {vga_valid, vga_data}, {1'b1, 8'h5A});
    tick;
    check("vga_hi", {vga_valid, vga_data}, {1'b1, 8'hA5});
    tick;
    check("vga_valid_end", vga_valid, 1'b0);
    // collision: VGA first, CPU one cycle later
    vga_req = 1'b1; vga_addr = 15'h0080;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    tick;
    vga_req = 1'b0;
    check("col_vga_first", ram_addr, 14'h0040);
    tick;
    check("col_cpu_next", ram_addr, 14'h0123);
    tick;
    check("col_vvalid", {vga_valid, cpu_ack}, 2'b10);
    tick;
    check("col_ack", {vga_valid, cpu_ack}, 2'b01);
    check("col_rdata", cpu_rdata, 16'hBEEF);
    cpu_req = 1'b0;
    tick;
    // starvation: VGA every cycle, CPU read pending
    grant_edge = 0; miss_cnt = 0; ack_edge = 0; valid_cnt = 0;
    vga_req = 1'b1; vga_addr = 15'h0081;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    for (int e = 1; e <= 24; e++) begin
      tick;
      if (grant_edge == 0 && ram_addr == 14'h0123) grant_edge = e;
      if (vga_miss) miss_cnt++;
      if (vga_valid) valid_cnt++;
      if (e == 16) check("starve_wait0", dut.wait_cnt, 0);
      if (e == 18) check("starve_miss_novalid", vga_valid, 1'b0);
      if (cpu_ack) begin
        if (ack_edge == 0) ack_edge = e;
        cpu_req = 1'b0;
      end
    end
    vga_req = 1'b0;
    check("starve_grant", grant_edge, 16);
    check("starve_miss", miss_cnt, 1);
    check("starve_ack", ack_edge, 18);
    check("starve_valid", valid_cnt, 21);
    check("starve_rdata", cpu_rdata, 16'hBEEF);
    repeat (3) tick;
    // cpu_req held high across acks: one access per ack, re-grant after ack
    we_cnt = 0; ack_cnt = 0; we2_edge = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 16'h1234;
    for (int e = 1; e <= 12; e++) begin
      tick;
      if (ram_we) begin
        we_cnt++;
        if (we_cnt == 2) we2_edge = e;
      end
      if (cpu_ack) ack_cnt++;
    end
    cpu_req = 1'b0;
    check("held_we_cnt", we_cnt, 3);
    check("held_ack_cnt", ack_cnt, 3);
    check("held_second", we2_edge, 5);
    repeat (4) tick;
    // reset one cycle after a CPU read grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040;
    tick;
    check("rst_granted", ram_addr, 14'h0040);
    rst_n = 1'b0;
    #1;
    outs_zero("midrst");
    tick;
    check("midrst_ack_a", cpu_ack, 1'b0);
    tick;
    check("midrst_ack_b", cpu_ack, 1'b0);
    rst_n = 1'b1;
    cpu_op("reissue", 1'b0, 14'h0040, 16'h0000, 16'hA55A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
